// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared types and constants for the program-counter sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package pc_pkg;

   // Next-PC select codes; codes 6 and 7 are treated as SEQ by the sequencer.
   typedef enum logic [2:0] {
      SEQ  = 3'd0,
      BR   = 3'd1,
      J    = 3'd2,
      JR   = 3'd3,
      RET  = 3'd4,
      ERET = 3'd5
   } pc_src_t;

   localparam int unsigned PC_STEP       = 4;
   localparam logic [31:0] RESET_VEC_DEF = 32'h0000_3000;
   localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_4180;

endpackage
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
//  Module      : pc_ras
//  Description : Circular return-address stack. A push into a full stack
//                overwrites the oldest entry; push+pop replaces the top.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_ras
   import pc_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [XLEN-1:0] push_data_i,
   output logic [XLEN-1:0] top_o,
   output logic            empty_o,
   output logic            full_o
);

   localparam int unsigned      PTR_W   = $clog2(RAS_DEPTH);
   localparam int unsigned      CNT_W   = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

   logic [XLEN-1:0]  mem_q [RAS_DEPTH];
   logic [PTR_W-1:0] sp_q, sp_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_en_w;
   logic [PTR_W-1:0] wr_idx_w;

   assign top_o   = mem_q[sp_q];
   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CNT_MAX);

   // Pointer/count update and write-slot selection for push, pop and replace.
   always_comb begin
      sp_d     = sp_q;
      cnt_d    = cnt_q;
      wr_en_w  = 1'b0;
      wr_idx_w = sp_q;
      if (push_i && pop_i) begin
         wr_en_w = 1'b1;
      end else if (push_i) begin
         sp_d     = sp_q + PTR_ONE;
         wr_en_w  = 1'b1;
         wr_idx_w = sp_q + PTR_ONE;
         if (!full_o) begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else if (pop_i && !empty_o) begin
         sp_d  = sp_q - PTR_ONE;
         cnt_d = cnt_q - CNT_ONE;
      end
   end

   // Stack storage, pointer and occupancy registers; reset clears every entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         sp_q  <= '0;
         cnt_q <= '0;
      end else begin
         sp_q  <= sp_d;
         cnt_q <= cnt_d;
         if (wr_en_w) begin
            mem_q[wr_idx_w] <= push_data_i;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Owns the PC and EPC registers, selects the next PC, traps
//                misaligned or underflowing targets to the exception vector.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
   parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(EXC_VEC_DEF),
   parameter int unsigned     RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic [2:0]      pc_src_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic [25:0]     jtarget_i,
   input  logic [XLEN-1:0] reg_target_i,
   input  logic            exc_req_i,
   input  logic            ras_push_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc4_o,
   output logic [XLEN-1:0] epc_o,
   output logic            fault_o,
   output logic            ras_empty_o
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic            fault_q, fault_d;
   logic [XLEN-1:0] pc4_w;
   logic [XLEN-1:0] cand_w;
   logic [XLEN-1:0] ras_top_w;
   logic            ras_empty_w;
   logic            unused_ras_full_w;
   logic            ras_pop_w;
   logic            ras_push_w;
   logic            indirect_w;
   logic            fault_cond_w;

   assign pc4_w = pc_q + XLEN'(PC_STEP);

   // Candidate next PC for the selected flow.
   always_comb begin
      cand_w = pc4_w;
      case (pc_src_i)
         BR:      cand_w = pc4_w + (imm_i << 2);
         J:       cand_w = {pc4_w[XLEN-1:28], jtarget_i, 2'b00};
         JR:      cand_w = reg_target_i;
         RET:     cand_w = ras_top_w;
         ERET:    cand_w = epc_q;
         default: cand_w = pc4_w;
      endcase
   end

   // Indirect targets must be word aligned; a return needs a stacked address.
   assign indirect_w   = (pc_src_i == JR) || (pc_src_i == RET) || (pc_src_i == ERET);
   assign fault_cond_w = (indirect_w && (cand_w[1:0] != 2'b00)) ||
                         ((pc_src_i == RET) && ras_empty_w);

   // Per-edge priority: exception, then trap, then stall, then normal advance.
   always_comb begin
      pc_d       = pc_q;
      epc_d      = epc_q;
      fault_d    = 1'b0;
      ras_pop_w  = 1'b0;
      ras_push_w = 1'b0;
      if (exc_req_i) begin
         pc_d  = EXC_VEC;
         epc_d = pc_q;
      end else if (fault_cond_w && !stall_i) begin
         pc_d    = EXC_VEC;
         epc_d   = pc_q;
         fault_d = 1'b1;
      end else if (!stall_i) begin
         pc_d       = cand_w;
         ras_pop_w  = (pc_src_i == RET);
         ras_push_w = ras_push_i;
      end
   end

   // PC, EPC and registered fault pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_VEC;
         epc_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         epc_q   <= epc_d;
         fault_q <= fault_d;
      end
   end

   pc_ras #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (ras_push_w),
      .pop_i       (ras_pop_w),
      .push_data_i (pc4_w),
      .top_o       (ras_top_w),
      .empty_o     (ras_empty_w),
      .full_o      (unused_ras_full_w)
   );

   assign pc_o        = pc_q;
   assign pc4_o       = pc4_w;
   assign epc_o       = epc_q;
   assign fault_o     = fault_q;
   assign ras_empty_o = ras_empty_w;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Scoreboard bench for pc_sequencer with a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

   localparam logic [31:0] C_RESET = 32'h0000_3000;
   localparam logic [31:0] C_EXC   = 32'h0000_4180;
   localparam int          C_DEPTH = 4;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] epc;
      logic        fault;
      logic        empty;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic [2:0]  pc_src;
   logic [31:0] imm;
   logic [25:0] jtarget;
   logic [31:0] reg_target;
   logic        exc_req;
   logic        ras_push;
   logic [31:0] pc_o;
   logic [31:0] pc4_o;
   logic [31:0] epc_o;
   logic        fault_o;
   logic        ras_empty_o;

   // Reference state: PC, EPC, fault pulse and the return stack as a queue.
   logic [31:0] m_pc;
   logic [31:0] m_epc;
   logic        m_fault;
   logic [31:0] ras_m[$];
   exp_t        exp_q[$];

   int n_cmp = 0;
   int n_err = 0;

   pc_sequencer #(
      .XLEN      (32),
      .RESET_VEC (C_RESET),
      .EXC_VEC   (C_EXC),
      .RAS_DEPTH (C_DEPTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall_i      (stall),
      .pc_src_i     (pc_src),
      .imm_i        (imm),
      .jtarget_i    (jtarget),
      .reg_target_i (reg_target),
      .exc_req_i    (exc_req),
      .ras_push_i   (ras_push),
      .pc_o         (pc_o),
      .pc4_o        (pc4_o),
      .epc_o        (epc_o),
      .fault_o      (fault_o),
      .ras_empty_o  (ras_empty_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Drive one cycle of inputs, advance the model, queue the expected state.
   task automatic step(input logic st, input logic [2:0] src, input logic [31:0] im,
                       input logic [25:0] jt, input logic [31:0] rt,
                       input logic ex, input logic pu);
      logic [31:0] p4;
      logic [31:0] tgt;
      logic        bad;
      exp_t        e;
      stall = st; pc_src = src; imm = im; jtarget = jt;
      reg_target = rt; exc_req = ex; ras_push = pu;
      p4 = m_pc + 32'd4;
      case (src)
         3'd1:    tgt = p4 + im * 32'd4;
         3'd2:    tgt = {p4[31:28], jt, 2'b00};
         3'd3:    tgt = rt;
         3'd4:    tgt = (ras_m.size() > 0) ? ras_m[$] : 32'd0;
         3'd5:    tgt = m_epc;
         default: tgt = p4;
      endcase
      bad = ((src == 3'd3 || src == 3'd4 || src == 3'd5) && tgt[1:0] != 2'b00) ||
            (src == 3'd4 && ras_m.size() == 0);
      m_fault = 1'b0;
      if (ex) begin
         m_epc = m_pc;
         m_pc  = C_EXC;
      end else if (bad && !st) begin
         m_epc   = m_pc;
         m_pc    = C_EXC;
         m_fault = 1'b1;
      end else if (!st) begin
         m_pc = tgt;
         if (src == 3'd4) begin
            if (pu) ras_m[ras_m.size()-1] = p4;
            else    void'(ras_m.pop_back());
         end else if (pu) begin
            ras_m.push_back(p4);
            if (ras_m.size() > C_DEPTH) void'(ras_m.pop_front());
         end
      end
      e.pc = m_pc; e.pc4 = m_pc + 32'd4; e.epc = m_epc;
      e.fault = m_fault; e.empty = (ras_m.size() == 0);
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic seq(input logic pu);
      step(1'b0, 3'd0, 32'd0, 26'd0, 32'd0, 1'b0, pu);
   endtask

   // Called at a falling edge: drop reset mid-cycle, check, release next fall.
   task automatic do_reset();
      stall = 1'b0; pc_src = 3'd0; imm = '0; jtarget = '0;
      reg_target = '0; exc_req = 1'b0; ras_push = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_pc",    pc_o,        C_RESET);
      chk("rst_pc4",   pc4_o,       C_RESET + 32'd4);
      chk("rst_epc",   epc_o,       32'd0);
      chk("rst_fault", {31'd0, fault_o},     32'd0);
      chk("rst_empty", {31'd0, ras_empty_o}, 32'd1);
      m_pc = C_RESET; m_epc = 32'd0; m_fault = 1'b0;
      ras_m.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: after each rising edge, compare the DUT against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc",    pc_o,  e.pc);
            chk("pc4",   pc4_o, e.pc4);
            chk("epc",   epc_o, e.epc);
            chk("fault", {31'd0, fault_o},     {31'd0, e.fault});
            chk("empty", {31'd0, ras_empty_o}, {31'd0, e.empty});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  r_src;
      logic [31:0] r_im;
      logic [31:0] r_rt;
      rst_n = 1'b0;
      stall = 1'b0; pc_src = 3'd0; imm = '0; jtarget = '0;
      reg_target = '0; exc_req = 1'b0; ras_push = 1'b0;
      m_pc = C_RESET; m_epc = 32'd0; m_fault = 1'b0;
      @(negedge clk);
      do_reset();

      // Sequential, branch back by two words, then J-type.
      for (int i = 0; i < 3; i++) seq(1'b0);
      chk("seq3_pc", pc_o, 32'h0000_300C);
      seq(1'b0);
      step(1'b0, 3'd1, 32'hFFFF_FFFE, 26'd0, 32'd0, 1'b0, 1'b0);
      chk("br_pc", pc_o, 32'h0000_300C);
      step(1'b0, 3'd2, 32'd0, 26'h0000100, 32'd0, 1'b0, 1'b0);
      chk("j_pc", pc_o, 32'h0000_0400);

      // Call / return, then overflow the stack and underflow on the fifth return.
      do_reset();
      seq(1'b1);
      seq(1'b0);
      step(1'b0, 3'd4, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0);
      chk("ret_pc", pc_o, 32'h0000_3004);
      chk("ret_empty", {31'd0, ras_empty_o}, 32'd1);
      for (int i = 0; i < 5; i++) seq(1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 3'd4, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0);
      chk("ret5_pc", pc_o, C_EXC);
      chk("ret5_fault", {31'd0, fault_o}, 32'd1);

      // Misaligned register jump traps; ERET returns to the trapping PC.
      do_reset();
      for (int i = 0; i < 8; i++) seq(1'b0);
      step(1'b0, 3'd3, 32'd0, 26'd0, 32'h0000_3002, 1'b0, 1'b0);
      chk("jr_pc", pc_o, C_EXC);
      chk("jr_epc", epc_o, 32'h0000_3020);
      chk("jr_fault", {31'd0, fault_o}, 32'd1);
      step(1'b0, 3'd5, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0);
      chk("eret_pc", pc_o, 32'h0000_3020);
      chk("eret_fault", {31'd0, fault_o}, 32'd0);

      // Exception wins over stall and RET; stack depth must be unchanged.
      do_reset();
      for (int i = 0; i < 16; i++) seq(i < 2);
      step(1'b1, 3'd4, 32'd0, 26'd0, 32'd0, 1'b1, 1'b0);
      chk("exc_pc", pc_o, C_EXC);
      chk("exc_epc", epc_o, 32'h0000_3040);
      chk("exc_fault", {31'd0, fault_o}, 32'd0);
      step(1'b0, 3'd4, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0);
      chk("exc_ret1", pc_o, 32'h0000_3008);
      step(1'b0, 3'd4, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0);
      chk("exc_ret2", pc_o, 32'h0000_3004);
      chk("exc_empty", {31'd0, ras_empty_o}, 32'd1);

      // Reset with three stacked entries discards them.
      do_reset();
      for (int i = 0; i < 3; i++) seq(1'b1);
      do_reset();
      step(1'b0, 3'd4, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0);
      chk("rst_ret_pc", pc_o, C_EXC);
      chk("rst_ret_fault", {31'd0, fault_o}, 32'd1);

      // Randomized traffic against the model, with occasional resets.
      for (int n = 0; n < 1500; n++) begin
         if (n % 500 == 499) do_reset();
         r_src = 3'($urandom_range(0, 7));
         r_im  = 32'($urandom_range(0, 31)) - 32'd16;
         r_rt  = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         step($urandom_range(0, 7) == 0, r_src, r_im, 26'($urandom), r_rt,
              $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
      end

      @(posedge clk);
      #2;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the single-cycle/multi-cycle CPU datapath. It is the parametrised successor of the combinational next-PC mux. It owns the PC register and computes the next PC for sequential, branch, jump, register-jump, return and exception-return flows. It also holds a small return-address stack (RAS) and an exception PC (EPC), and traps misaligned or underflowing targets to the exception vector. It sits between the control unit (which drives `pc_src`, `stall` and `exc_req`) and the instruction memory address port.

## Interface
Parameters:
- `XLEN`, 32, PC/datapath width; must be ≥ 32.
- `RESET_VEC`, 32'h0000_3000, PC value after reset.
- `EXC_VEC`, 32'h0000_4180, PC value on exception or fault.
- `RAS_DEPTH`, 4, number of RAS entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  rising-edge clock; the block's only clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `stall`  in  1  hold PC, EPC and RAS; exceptions still taken.
- `pc_src`  in  3  next-PC select (encodings in package).
- `imm`  in  XLEN  sign-extended branch offset in words.
- `jtarget`  in  26  J-type target field.
- `reg_target`  in  XLEN  register-jump target.
- `exc_req`  in  1  external exception request.
- `ras_push`  in  1  call: push current PC+4 onto RAS.
- `pc`  out  XLEN  current PC (registered).
- `pc4`  out  XLEN  pc+4 (combinational).
- `epc`  out  XLEN  saved exception PC (registered).
- `fault`  out  1  one-cycle pulse: misaligned target or RAS underflow trapped.
- `ras_empty`  out  1  RAS holds no entries.

## Operation
- All arithmetic is modulo 2^XLEN.
- Candidate next PC by `pc_src`:
  - `SEQ`=0: pc4.
  - `BR`=1: pc4 + (imm << 2).
  - `J`=2: {pc4[XLEN-1:28], jtarget, 2'b00}.
  - `JR`=3: reg_target.
  - `RET`=4: RAS top; pops one entry.
  - `ERET`=5: epc.
  - Codes 6 and 7 behave as `SEQ`.
- Fault condition: a `JR`, `RET` or `ERET` target with bits [1:0] ≠ 0, or `RET` while `ras_empty`.
- Per-edge priority:
  1. `exc_req`: pc←EXC_VEC, epc←pc. RAS is untouched and `fault` stays 0.
  2. Fault condition with `!stall`: pc←EXC_VEC, epc←pc, fault←1. There is no pop and no push.
  3. `stall`: all state holds.
  4. Otherwise: pc←candidate, and RAS pop/push as below.
- RAS is a circular stack with pointer and count.
  - Push writes pc4.
  - Push while full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - `RET` together with `ras_push` replaces the top with pc4; count is unchanged.
  - `ras_push` with a faulting or excepting cycle is discarded.
- `ras_empty` = (count == 0).

## Timing
- Reset (async on `rst_n` low):
  - pc=RESET_VEC, epc=0, fault=0.
  - RAS count=0 and all RAS entries=0, so ras_empty=1.
  - pc4=RESET_VEC+4.
- Release of `rst_n` is synchronised by the system. The first update happens on the first rising edge with `rst_n` high.
- Latency: inputs sampled at edge N take effect on pc at edge N; pc is visible after edge N. pc4 follows pc combinationally.
- `fault` is registered and high for exactly the cycle after the trapping edge. Back-to-back faults keep it high.
- `exc_req` held for k cycles re-enters EXC_VEC k times. On each of those edges, epc captures the pc current at that edge.
- Reset mid-operation discards the RAS contents and any pending fault.

## Structure
- Package `pc_pkg`:
  - `pc_src_t` enum (SEQ, BR, J, JR, RET, ERET).
  - `PC_STEP`=4.
  - Default RESET_VEC/EXC_VEC constants.
- Sub-module `pc_ras` (parameters XLEN, RAS_DEPTH).
  - Inputs: push, pop, push_data.
  - Outputs: top, empty, full.
  - Async reset, same clock.
- Top holds the PC/EPC registers, the candidate mux, fault detection and priority.

## Test plan
- Reset then 3 idle cycles with `SEQ` -> pc = 0x3000, 0x3004, 0x3008, 0x300C; epc=0; ras_empty=1.
- At pc=0x3010, `BR` with imm=-2 (0xFFFF_FFFE) -> pc=0x300C. Next, `J` with jtarget=0x0000100 -> pc=0x0000_0400.
- Push at pc=0x3000, then `SEQ`, then `RET` -> pc=0x3004 and ras_empty=1. With RAS_DEPTH=4, five pushes then five RETs -> the fifth RET faults to 0x4180 (oldest entry overwritten).
- `JR` with reg_target=0x3002 at pc=0x3020 -> pc=0x4180, epc=0x3020, fault high one cycle. `ERET` -> pc=0x3020.
- `exc_req` together with `stall` and `pc_src=RET` at pc=0x3040 -> pc=0x4180, epc=0x3040, RAS count unchanged, fault=0.
- `rst_n` dropped mid-cycle with RAS holding 3 entries -> pc=0x3000 immediately, ras_empty=1; a following `RET` faults.
